// File: rtl/gemm_pkg.sv
// Shared types and default widths for the GEMM loop controller.
package gemm_pkg;

    localparam int unsigned AddrWidthDef     = 12;
    localparam int unsigned SizeAddrWidthDef = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    // One slot of the issue -> MAC -> C-write pipeline.
    typedef struct packed {
        logic                    valid;
        logic                    first;
        logic                    last;
        logic [AddrWidthDef-1:0] c_addr;
    } pipe_bundle_t;

endpackage

// File: rtl/gemm_loop_controller_if.sv
// Job control, SRAM address and MAC strobe bundle between the controller and its surroundings.
interface gemm_loop_controller_if #(
    parameter int unsigned AddrWidth     = gemm_pkg::AddrWidthDef,
    parameter int unsigned SizeAddrWidth = gemm_pkg::SizeAddrWidthDef
);
    logic                     start_i;
    logic [SizeAddrWidth-1:0] M_size_i;
    logic [SizeAddrWidth-1:0] K_size_i;
    logic [SizeAddrWidth-1:0] N_size_i;
    logic [AddrWidth-1:0]     sram_a_addr_o;
    logic [AddrWidth-1:0]     sram_b_addr_o;
    logic                     mac_valid_o;
    logic                     mac_first_o;
    logic                     mac_last_o;
    logic [AddrWidth-1:0]     sram_c_addr_o;
    logic                     sram_c_we_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, M_size_i, K_size_i, N_size_i,
        input  sram_a_addr_o, sram_b_addr_o, mac_valid_o, mac_first_o, mac_last_o,
        input  sram_c_addr_o, sram_c_we_o, busy_o, done_o
    );

    modport slave (
        input  start_i, M_size_i, K_size_i, N_size_i,
        output sram_a_addr_o, sram_b_addr_o, mac_valid_o, mac_first_o, mac_last_o,
        output sram_c_addr_o, sram_c_we_o, busy_o, done_o
    );
endinterface

// File: rtl/gemm_wrap_counter.sv
// Up-counter that returns to zero after reaching max; wrap_o flags the step that wraps.
module gemm_wrap_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic [Width-1:0] max_i,
    output logic [Width-1:0] count_o,
    output logic             wrap_o
);
    logic [Width-1:0] r_count;

    assign wrap_o  = en_i && (r_count == max_i);
    assign count_o = r_count;

    // Count register: clear wins, otherwise step or wrap on enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= wrap_o ? '0 : r_count + Width'(1);
        end
    end
endmodule

// File: rtl/gemm_loop_controller.sv
// Walks the m -> n -> k loop nest, generates A/B/C SRAM addresses without multipliers
// and delays the MAC/C-write strobes to line up with the 1-cycle SRAM read.
//
//   state | meaning
//   IDLE  | waiting for start_i, sizes sampled on accept
//   RUN   | one (m,n,k) read issued per cycle
//   DRAIN | two cycles letting the last issue reach the MAC and the C write
//   DONE  | one-cycle done_o pulse
module gemm_loop_controller #(
    parameter int unsigned AddrWidth     = gemm_pkg::AddrWidthDef,
    parameter int unsigned SizeAddrWidth = gemm_pkg::SizeAddrWidthDef
) (
    input logic clk_i,
    input logic rst_ni,
    gemm_loop_controller_if.slave bus
);
    import gemm_pkg::*;

    localparam int unsigned Sw = SizeAddrWidth;
    localparam int unsigned Aw = AddrWidth;

    ctrl_state_e   r_state, w_state_next;
    logic          r_drain_cnt;
    logic [Sw-1:0] r_m_size, r_k_size, r_n_size;
    logic [Sw-1:0] w_k_cnt, w_n_cnt, w_m_cnt_unused;
    logic          w_k_wrap, w_n_wrap, w_m_wrap;
    logic          w_issue, w_idle, w_sizes_ok;
    logic [Aw-1:0] r_a_base, r_b_addr, r_c_cnt, r_a_last, r_b_last;
    logic [Aw-1:0] w_a_live;
    pipe_bundle_t  r_s1, r_s2;

    assign w_issue    = (r_state == RUN);
    assign w_idle     = (r_state == IDLE);
    assign w_sizes_ok = (|bus.M_size_i) && (|bus.K_size_i) && (|bus.N_size_i);
    assign w_a_live   = r_a_base + Aw'(w_k_cnt);

    gemm_wrap_counter #(.Width(Sw)) u_k_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(w_issue), .clear_i(w_idle),
        .max_i(r_k_size - Sw'(1)), .count_o(w_k_cnt), .wrap_o(w_k_wrap)
    );
    gemm_wrap_counter #(.Width(Sw)) u_n_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(w_k_wrap), .clear_i(w_idle),
        .max_i(r_n_size - Sw'(1)), .count_o(w_n_cnt), .wrap_o(w_n_wrap)
    );
    gemm_wrap_counter #(.Width(Sw)) u_m_cnt (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(w_n_wrap), .clear_i(w_idle),
        .max_i(r_m_size - Sw'(1)), .count_o(w_m_cnt_unused), .wrap_o(w_m_wrap)
    );

    // State register and drain-cycle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= (r_state == DRAIN) ? ~r_drain_cnt : 1'b0;
        end
    end

    // Next-state decode; the m-counter wrap marks the final issue of the job.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start_i) w_state_next = w_sizes_ok ? RUN : DONE;
            RUN:     if (w_m_wrap) w_state_next = DRAIN;
            DRAIN:   if (r_drain_cnt) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Size latch on accept; incremental A base, B address and C pair index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_m_size <= '0;
            r_k_size <= '0;
            r_n_size <= '0;
            r_a_base <= '0;
            r_b_addr <= '0;
            r_c_cnt  <= '0;
            r_a_last <= '0;
            r_b_last <= '0;
        end else begin
            if (w_idle && bus.start_i) begin
                r_m_size <= bus.M_size_i;
                r_k_size <= bus.K_size_i;
                r_n_size <= bus.N_size_i;
            end
            if (w_issue) begin
                r_a_last <= w_a_live;
                r_b_last <= r_b_addr;
            end
            if (w_idle) begin
                r_a_base <= '0;
                r_b_addr <= '0;
                r_c_cnt  <= '0;
            end else begin
                if (w_n_wrap) r_a_base <= w_m_wrap ? '0 : r_a_base + Aw'(r_k_size);
                if (w_k_wrap) begin
                    r_b_addr <= w_n_wrap ? '0 : Aw'(w_n_cnt) + Aw'(1);
                    r_c_cnt  <= w_m_wrap ? '0 : r_c_cnt + Aw'(1);
                end else if (w_issue) begin
                    r_b_addr <= r_b_addr + Aw'(r_n_size);
                end
            end
        end
    end

    // Stage 1 follows the read issue by one cycle; stage 2 keeps only dot-product ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1        <= '0;
            if (w_issue) begin
                r_s1.valid  <= 1'b1;
                r_s1.first  <= (w_k_cnt == '0);
                r_s1.last   <= w_k_wrap;
                r_s1.c_addr <= AddrWidthDef'(r_c_cnt);
            end
            r_s2 <= (r_s1.valid && r_s1.last) ? r_s1 : '0;
        end
    end

    assign bus.sram_a_addr_o = (r_state == DRAIN) ? r_a_last : w_a_live;
    assign bus.sram_b_addr_o = (r_state == DRAIN) ? r_b_last : r_b_addr;
    assign bus.mac_valid_o   = r_s1.valid;
    assign bus.mac_first_o   = r_s1.first;
    assign bus.mac_last_o    = r_s1.last;
    assign bus.sram_c_we_o   = r_s2.valid;
    assign bus.sram_c_addr_o = Aw'(r_s2.c_addr);
    assign bus.busy_o        = !w_idle;
    assign bus.done_o        = (r_state == DONE);
endmodule
